// File: rtl/dot_prod_unit_pkg.sv
// Shared sizing defaults for the dot-product reduction path, plus the
// helper that locates a lane inside a flattened lane bus.
package dot_prod_unit_pkg;

  localparam int DEF_LANES      = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;

  // Bit offset of lane `lane` in a bus of `width`-bit lanes (lane 0 at the LSBs).
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dot_prod_unit_adder_tree.sv
// Balanced combinational reduction of LANES two's-complement lanes into a
// single wrapping sum; one adder level per halving of the lane count.
module adder_tree
  import dot_prod_unit_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [LANES*DATA_WIDTH-1:0] lanes,
  output logic [DATA_WIDTH-1:0]       sum
);

  localparam int LEVELS = $clog2(LANES);

  // Level l holds LANES >> l partial sums; level LEVELS is the final total.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int WIDTH = LANES >> l;
    logic [DATA_WIDTH-1:0] node [WIDTH];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < WIDTH; i++) begin : g_in
        assign node[i] = lanes[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end else begin : g_add
      for (genvar i = 0; i < WIDTH; i++) begin : g_sum
        assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
      end
    end
  end

  assign sum = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/dot_prod_unit.sv
// Two-stage dot-product unit: stage 1 registers the lane reduction, stage 2
// accumulates it or pushes the finished dot product into the result vector.
module dot_prod_unit
  import dot_prod_unit_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  input  logic                        dot_prod_en,
  input  logic                        shift,
  input  logic [ADDR_WIDTH-1:0]       r_addr_in,
  input  logic [LANES*DATA_WIDTH-1:0] prod,
  input  logic                        clear,
  output logic [LANES*DATA_WIDTH-1:0] out_vec,
  output logic                        out_valid,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [DATA_WIDTH-1:0]       acc_out,
  output logic [$clog2(LANES):0]      lane_cnt
);

  localparam int CNT_W = $clog2(LANES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LANES);

  logic                  accept;
  logic [DATA_WIDTH-1:0] tree_sum;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  s1_valid;
  logic                  s1_shift;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_sum;

  assign accept = in_valid && dot_prod_en;

  adder_tree #(
    .LANES      (LANES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tree (
    .lanes (prod),
    .sum   (tree_sum)
  );

  // Stage 2 only ever reads the registered sum, so back-to-back ops need no bypass.
  assign acc_sum = acc + sum_q;
  assign acc_out = acc;

  // NOTE: every state element uses non-blocking assignment so all registers
  // sample pre-edge values and the two stages advance in lockstep.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sum_q     <= '0;
      s1_valid  <= 1'b0;
      s1_shift  <= 1'b0;
      s1_addr   <= '0;
      acc       <= '0;
      out_vec   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      lane_cnt  <= '0;
    end else if (clear) begin
      s1_valid  <= 1'b0;
      acc       <= '0;
      out_vec   <= '0;
      out_valid <= 1'b0;
      lane_cnt  <= '0;
    end else begin
      s1_valid  <= accept;
      out_valid <= 1'b0;
      if (accept) begin
        sum_q    <= tree_sum;
        s1_shift <= shift;
        s1_addr  <= r_addr_in;
      end
      if (s1_valid) begin
        if (s1_shift) begin
          // Newest result enters lane 0; the oldest lane falls off the top.
          out_vec   <= {out_vec[(LANES-1)*DATA_WIDTH-1:0], acc_sum};
          acc       <= '0;
          out_addr  <= s1_addr;
          out_valid <= 1'b1;
          if (lane_cnt != CNT_MAX) lane_cnt <= lane_cnt + 1'b1;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_prod_unit.sv
// Randomised and directed checks of dot_prod_unit against a transaction-level
// model: each accepted op's lane sum takes effect one edge after it is taken.
module tb_dot_prod_unit;

  localparam int L  = 8;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int VW = L * DW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          dot_prod_en;
  logic          shift;
  logic [AW-1:0] r_addr_in;
  logic [VW-1:0] prod;
  logic          clear;
  logic [VW-1:0] out_vec;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] acc_out;
  logic [$clog2(L):0] lane_cnt;

  dot_prod_unit #(.LANES(L), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .dot_prod_en (dot_prod_en),
    .shift       (shift),
    .r_addr_in   (r_addr_in),
    .prod        (prod),
    .clear       (clear),
    .out_vec     (out_vec),
    .out_valid   (out_valid),
    .out_addr    (out_addr),
    .acc_out     (acc_out),
    .lane_cnt    (lane_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] sum;
    logic          sh;
    logic [AW-1:0] addr;
  } op_t;

  op_t           pend[$];
  logic [DW-1:0] m_vec [L];
  logic [DW-1:0] m_acc;
  int            m_cnt;
  logic          m_valid;
  logic [AW-1:0] m_addr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] all_lanes(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int k = 0; k < L; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] r;
    for (int k = 0; k < L; k++) r[k*DW +: DW] = m_vec[k];
    return r;
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int k = 0; k < L; k++) m_vec[k] = '0;
    m_acc = '0; m_cnt = 0; m_valid = 1'b0; m_addr = '0;
  endtask

  // Effect of one clock edge on the architectural state, given the inputs held across it.
  task automatic model_edge(input logic iv, en, sh, input logic [AW-1:0] a,
                            input logic [VW-1:0] p, input logic clr, input logic rn);
    op_t o;
    logic [DW-1:0] s;
    if (!rn) begin
      model_reset();
      return;
    end
    if (clr) begin
      pend.delete();
      for (int k = 0; k < L; k++) m_vec[k] = '0;
      m_acc = '0; m_cnt = 0; m_valid = 1'b0;
      return;
    end
    m_valid = 1'b0;
    if (pend.size() > 0) begin
      o = pend.pop_front();
      if (o.sh) begin
        for (int k = L-1; k > 0; k--) m_vec[k] = m_vec[k-1];
        m_vec[0] = m_acc + o.sum;
        m_acc    = '0;
        m_addr   = o.addr;
        m_valid  = 1'b1;
        if (m_cnt < L) m_cnt++;
      end else begin
        m_acc = m_acc + o.sum;
      end
    end
    if (iv && en) begin
      s = '0;
      for (int k = 0; k < L; k++) s = s + p[k*DW +: DW];
      o.sum = s; o.sh = sh; o.addr = a;
      pend.push_back(o);
    end
  endtask

  task automatic step(input logic iv, en, sh, input logic [AW-1:0] a,
                      input logic [VW-1:0] p, input logic clr, input logic rn);
    in_valid = iv; dot_prod_en = en; shift = sh; r_addr_in = a;
    prod = p; clear = clr; rstn = rn;
    @(posedge clk);
    model_edge(iv, en, sh, a, p, clr, rn);
    #1;
    check("out_valid", VW'(out_valid), VW'(m_valid));
    check("out_vec",   out_vec,        model_vec());
    check("out_addr",  VW'(out_addr),  VW'(m_addr));
    check("acc_out",   VW'(acc_out),   VW'(m_acc));
    check("lane_cnt",  VW'(lane_cnt),  VW'(m_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 1);
  endtask

  initial begin
    logic [VW-1:0] p;
    logic          rn;
    model_reset();
    in_valid = 0; dot_prod_en = 0; shift = 0; r_addr_in = '0;
    prod = '0; clear = 0; rstn = 0;

    // Reset then idle
    step(0, 0, 0, '0, '0, 0, 0);
    step(0, 0, 0, '0, '0, 0, 0);
    idle(4);
    check("idle_vec", out_vec, '0);

    // Single shift straight after reset
    step(1, 1, 1, 10'h005, all_lanes(1), 0, 1);
    idle(1);
    check("single_valid", VW'(out_valid), VW'(1));
    check("single_lane0", VW'(out_vec[DW-1:0]), VW'(8));
    check("single_addr",  VW'(out_addr), VW'(10'h005));
    check("single_acc",   VW'(acc_out), '0);
    check("single_cnt",   VW'(lane_cnt), VW'(1));
    idle(2);

    // Accumulate chain: 8+16+24+32
    step(1, 1, 0, 10'h010, all_lanes(1), 0, 1);
    step(1, 1, 0, 10'h011, all_lanes(2), 0, 1);
    step(1, 1, 0, 10'h012, all_lanes(3), 0, 1);
    step(1, 1, 1, 10'h013, all_lanes(4), 0, 1);
    idle(1);
    check("chain_lane0", VW'(out_vec[DW-1:0]), VW'(80));
    idle(1);
    check("chain_pulse", VW'(out_valid), '0);

    // Vector fill and overflow
    step(0, 0, 0, '0, '0, 1, 1);
    for (int k = 1; k <= 9; k++) step(1, 1, 1, AW'(k), all_lanes(DW'(k)), 0, 1);
    idle(2);
    check("fill_cnt", VW'(lane_cnt), VW'(8));
    for (int k = 0; k < L; k++) check("fill_lane", VW'(out_vec[k*DW +: DW]), VW'((9-k)*8));

    // Two's-complement wrap
    p = '0;
    p[DW-1:0]    = 32'h7FFF_FFFF;
    p[2*DW-1:DW] = 32'h1;
    step(1, 1, 1, 10'h3FF, p, 0, 1);
    idle(1);
    check("wrap_lane0", VW'(out_vec[DW-1:0]), VW'(32'h8000_0000));

    // Clear with an in-flight accumulate and a simultaneous shift accept
    step(1, 1, 0, 10'h020, all_lanes(5), 0, 1);
    step(1, 1, 1, 10'h021, all_lanes(6), 1, 1);
    idle(3);
    check("clr_acc", VW'(acc_out), '0);
    check("clr_cnt", VW'(lane_cnt), '0);
    check("clr_vec", out_vec, '0);

    // Reset while stage 1 holds a shift
    step(1, 1, 1, 10'h030, all_lanes(7), 0, 1);
    step(0, 0, 0, '0, '0, 0, 0);
    idle(3);
    check("rst_vec", out_vec, '0);
    check("rst_cnt", VW'(lane_cnt), '0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < L; k++) p[k*DW +: DW] = $urandom;
      rn = ($urandom_range(0, 150) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) == 0, AW'($urandom), p,
           $urandom_range(0, 40) == 0, rn);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
